// File: rtl/nano9k_led_pkg.sv
// Shared constants for the Nano 9K LED fader: PWM resolution and the board clock
// from which the default fade divider is derived.
package nano9k_led_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam logic [PWM_BITS_DEF-1:0] PWM_MAX = '1;

  localparam int CLK_HZ = 27_000_000;
  // One brightness step per millisecond, so a full 0..255 ramp is roughly 255 ms.
  localparam int FADE_DIV_DEF = CLK_HZ / 1000;

endpackage

// File: rtl/nano9k_led_channel.sv
// One LED channel: brightness register, step toward target level, PWM compare.
// With NANO9K_LED_FADE_EN undefined the brightness snaps to the target level.
module nano9k_led_channel
  import nano9k_led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
`ifdef NANO9K_LED_FADE_EN
  input  logic                i_tick,
  output logic                o_at_target,
`endif
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_target,
  output logic                o_on_q
);

  logic [PWM_BITS-1:0] r_bright;
  logic [PWM_BITS-1:0] w_level;

  assign w_level = {PWM_BITS{i_target}};

`ifdef NANO9K_LED_FADE_EN
  logic [PWM_BITS-1:0] w_next;

  // Single-step move toward the level; the equality case holds, so no overshoot.
  always_comb begin
    w_next = r_bright;
    if (r_bright < w_level) begin
      w_next = r_bright + 1'b1;
    end else if (r_bright > w_level) begin
      w_next = r_bright - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else if (i_tick) begin
      r_bright <= w_next;
    end
  end

  assign o_at_target = (r_bright == w_level);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else begin
      r_bright <= w_level;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_on_q <= 1'b0;
    end else begin
      o_on_q <= (r_bright > i_pwm_cnt);
    end
  end

endmodule

// File: rtl/nano9k_led_fader.sv
// Nano 9K LED output stage: per-LED PWM with a linear fade toward each target bit.
// Define NANO9K_LED_FADE_EN for fading; otherwise brightness snaps to the target.
module nano9k_led_fader
  import nano9k_led_pkg::*;
#(
  parameter int N_LEDS     = 6,
  parameter int PWM_BITS   = PWM_BITS_DEF,
`ifdef NANO9K_LED_FADE_EN
  parameter int FADE_DIV   = FADE_DIV_DEF,
`endif
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] target,
  input  logic              load,
  output logic [N_LEDS-1:0] leds,
  output logic              busy
);

  logic [N_LEDS-1:0]   r_target_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [N_LEDS-1:0]   w_on;

  // load is a plain capture strobe with no back-pressure: target is taken on every
  // edge where load=1 (pulse or held level); reloading the same value changes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target_q <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (load) begin
        r_target_q <= target;
      end
    end
  end

`ifdef NANO9K_LED_FADE_EN
  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [DIV_W-1:0]  r_div_cnt;
  logic              w_tick;
  logic [N_LEDS-1:0] w_at_target;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  assign busy = ~&w_at_target;
`else
  assign busy = 1'b0;
`endif

  generate
    for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
      nano9k_led_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
`ifdef NANO9K_LED_FADE_EN
        .i_tick      (w_tick),
        .o_at_target (w_at_target[g]),
`endif
        .i_pwm_cnt   (r_pwm_cnt),
        .i_target    (r_target_q[g]),
        .o_on_q      (w_on[g])
      );
    end
  endgenerate

  assign leds = ACTIVE_LOW ? ~w_on : w_on;

endmodule
